// File: rtl/rv_decode_unit_pkg.sv
// Shared types and encodings for the RV32I-subset decode stage.
package rv_decode_unit_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } aluControl_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immSrc_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } resultSrc_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluOp_t;

    typedef struct packed {
        logic       regWrite;
        immSrc_t    immSrc;
        logic       aluSrc;
        logic       memWrite;
        resultSrc_t resultSrc;
        logic       branch;
        aluOp_t     aluOp;
        logic       jump;
    } ctrlWord_t;

endpackage

// File: rtl/rv_decode_unit_if.sv
// Decode-stage bus: instruction and write-back port in, operands and control word out.
interface rv_decode_unit_if;
    import rv_decode_unit_pkg::*;

    logic [31:0]          Instr;
    logic                 WE3;
    logic [4:0]           A3;
    logic [WORD_SIZE-1:0] WD3;
    logic [WORD_SIZE-1:0] RD1;
    logic [WORD_SIZE-1:0] RD2;
    logic [4:0]           Rs1;
    logic [4:0]           Rs2;
    logic [4:0]           Rd;
    logic [WORD_SIZE-1:0] ImmExt;
    logic                 RegWrite;
    logic                 MemWrite;
    logic                 Jump;
    logic                 Branch;
    logic                 ALUSrc;
    logic                 ByteAddress;
    logic [1:0]           ResultSrc;
    logic [2:0]           ALUControl;
    logic [1:0]           ImmSrc;

    modport master (
        output Instr, WE3, A3, WD3,
        input  RD1, RD2, Rs1, Rs2, Rd, ImmExt, RegWrite, MemWrite, Jump,
               Branch, ALUSrc, ByteAddress, ResultSrc, ALUControl, ImmSrc
    );

    modport slave (
        input  Instr, WE3, A3, WD3,
        output RD1, RD2, Rs1, Rs2, Rd, ImmExt, RegWrite, MemWrite, Jump,
               Branch, ALUSrc, ByteAddress, ResultSrc, ALUControl, ImmSrc
    );
endinterface

// File: rtl/rv_decode_unit_regfile.sv
// 32x32 register file, x0 hardwired to zero; RF_BYPASS_EN enables write-through
// of the write-back port onto matching read ports.
module rv_regfile
    import rv_decode_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we3,
    input  logic [4:0]           a1,
    input  logic [4:0]           a2,
    input  logic [4:0]           a3,
    input  logic [WORD_SIZE-1:0] wd3,
    output logic [WORD_SIZE-1:0] rd1,
    output logic [WORD_SIZE-1:0] rd2
);
    logic [WORD_SIZE-1:0] regs [32];
    logic [WORD_SIZE-1:0] stored1;
    logic [WORD_SIZE-1:0] stored2;

    // Storage update; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= {WORD_SIZE{1'b0}};
            end
        end else if (we3 && (a3 != 5'd0)) begin
            regs[a3] <= wd3;
        end
    end

    assign stored1 = (a1 == 5'd0) ? {WORD_SIZE{1'b0}} : regs[a1];
    assign stored2 = (a2 == 5'd0) ? {WORD_SIZE{1'b0}} : regs[a2];

`ifdef RF_BYPASS_EN
    logic wbLive;
    assign wbLive = !rst && we3 && (a3 != 5'd0);
    assign rd1 = (wbLive && (a3 == a1)) ? wd3 : stored1;
    assign rd2 = (wbLive && (a3 == a2)) ? wd3 : stored2;
`else
    assign rd1 = stored1;
    assign rd2 = stored2;
`endif

endmodule

// File: rtl/rv_decode_unit.sv
// Decode stage: main/ALU control decode, immediate extension and register file.
// Optional macro RF_BYPASS_EN turns on register-file write-through.
module rv_decode_unit
    import rv_decode_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    rv_decode_unit_if.slave   bus
);
    logic [6:0]     op;
    logic [2:0]     funct3;
    logic           f7b5;
    ctrlWord_t      ctrl;
    aluControl_t    aluCtl;
    logic [WORD_SIZE-1:0] imm;

    assign op     = bus.Instr[6:0];
    assign funct3 = bus.Instr[14:12];
    assign f7b5   = bus.Instr[30];

    // Main decoder: unknown opcodes become a bubble.
    always_comb begin
        ctrl = '0;
        case (op)
            OP_LOAD:   ctrl = '{regWrite: 1'b1, immSrc: IMM_I, aluSrc: 1'b1, memWrite: 1'b0,
                                resultSrc: RES_MEM, branch: 1'b0, aluOp: ALUOP_ADD, jump: 1'b0};
            OP_STORE:  ctrl = '{regWrite: 1'b0, immSrc: IMM_S, aluSrc: 1'b1, memWrite: 1'b1,
                                resultSrc: RES_ALU, branch: 1'b0, aluOp: ALUOP_ADD, jump: 1'b0};
            OP_RTYPE:  ctrl = '{regWrite: 1'b1, immSrc: IMM_I, aluSrc: 1'b0, memWrite: 1'b0,
                                resultSrc: RES_ALU, branch: 1'b0, aluOp: ALUOP_FUNCT, jump: 1'b0};
            OP_BRANCH: ctrl = '{regWrite: 1'b0, immSrc: IMM_B, aluSrc: 1'b0, memWrite: 1'b0,
                                resultSrc: RES_ALU, branch: 1'b1, aluOp: ALUOP_SUB, jump: 1'b0};
            OP_ITYPE:  ctrl = '{regWrite: 1'b1, immSrc: IMM_I, aluSrc: 1'b1, memWrite: 1'b0,
                                resultSrc: RES_ALU, branch: 1'b0, aluOp: ALUOP_FUNCT, jump: 1'b0};
            OP_JAL:    ctrl = '{regWrite: 1'b1, immSrc: IMM_J, aluSrc: 1'b0, memWrite: 1'b0,
                                resultSrc: RES_PC4, branch: 1'b0, aluOp: ALUOP_ADD, jump: 1'b1};
            default:   ctrl = '0;
        endcase
    end

    // ALU decoder; only register-register ops with f7b5 set turn f3=000 into sub.
    always_comb begin
        aluCtl = ALU_ADD;
        case (ctrl.aluOp)
            ALUOP_ADD: aluCtl = ALU_ADD;
            ALUOP_SUB: aluCtl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (op[5] && f7b5) begin
                            aluCtl = ALU_SUB;
                        end else begin
                            aluCtl = ALU_ADD;
                        end
                    end
                    3'b010:  aluCtl = ALU_SLT;
                    3'b110:  aluCtl = ALU_OR;
                    3'b111:  aluCtl = ALU_AND;
                    default: aluCtl = ALU_ADD;
                endcase
            end
            default: aluCtl = ALU_ADD;
        endcase
    end

    // Immediate extender.
    always_comb begin
        imm = {WORD_SIZE{1'b0}};
        case (ctrl.immSrc)
            IMM_I:   imm = {{20{bus.Instr[31]}}, bus.Instr[31:20]};
            IMM_S:   imm = {{20{bus.Instr[31]}}, bus.Instr[31:25], bus.Instr[11:7]};
            IMM_B:   imm = {{20{bus.Instr[31]}}, bus.Instr[7], bus.Instr[30:25],
                            bus.Instr[11:8], 1'b0};
            IMM_J:   imm = {{12{bus.Instr[31]}}, bus.Instr[19:12], bus.Instr[20],
                            bus.Instr[30:21], 1'b0};
            default: imm = {WORD_SIZE{1'b0}};
        endcase
    end

    assign bus.Rs1         = bus.Instr[19:15];
    assign bus.Rs2         = bus.Instr[24:20];
    assign bus.Rd          = bus.Instr[11:7];
    assign bus.ImmExt      = imm;
    assign bus.RegWrite    = ctrl.regWrite;
    assign bus.MemWrite    = ctrl.memWrite;
    assign bus.Jump        = ctrl.jump;
    assign bus.Branch      = ctrl.branch;
    assign bus.ALUSrc      = ctrl.aluSrc;
    assign bus.ResultSrc   = ctrl.resultSrc;
    assign bus.ImmSrc      = ctrl.immSrc;
    assign bus.ALUControl  = aluCtl;
    assign bus.ByteAddress = ((op == OP_LOAD) || (op == OP_STORE)) && (funct3 == 3'b000);

    rv_regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .we3 (bus.WE3),
        .a1  (bus.Instr[19:15]),
        .a2  (bus.Instr[24:20]),
        .a3  (bus.A3),
        .wd3 (bus.WD3),
        .rd1 (bus.RD1),
        .rd2 (bus.RD2)
    );

endmodule

// File: tb/tb_rv_decode_unit.sv
// Directed self-checking bench for rv_decode_unit (register file and decoders).
module tb_rv_decode_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rv_decode_unit_if bus();

    rv_decode_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {RegWrite,MemWrite,Jump,Branch,ALUSrc,ByteAddress,ResultSrc,ALUControl,ImmSrc}
    logic [31:0] vInstr [12];
    logic [12:0] vCtrl  [12];
    logic [31:0] vImm   [12];
    string       vName  [12];

    initial begin
        vInstr = '{32'h402081B3, 32'hFFC4A303, 32'hFFC48303, 32'h0064A423,
                   32'h00648423, 32'hFE4208E3, 32'h001000EF, 32'h0000007F,
                   32'hFFF00093, 32'h007362B3, 32'h0031A0B3, 32'h003170B3};
        vCtrl  = '{13'b1_0_0_0_0_0_00_001_00, 13'b1_0_0_0_1_0_01_000_00,
                   13'b1_0_0_0_1_1_01_000_00, 13'b0_1_0_0_1_0_00_000_01,
                   13'b0_1_0_0_1_1_00_000_01, 13'b0_0_0_1_0_0_00_001_10,
                   13'b1_0_1_0_0_0_10_000_11, 13'b0_0_0_0_0_0_00_000_00,
                   13'b1_0_0_0_1_0_00_000_00, 13'b1_0_0_0_0_0_00_011_00,
                   13'b1_0_0_0_0_0_00_101_00, 13'b1_0_0_0_0_0_00_010_00};
        vImm   = '{32'h00000402, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000008,
                   32'h00000008, 32'hFFFFFFF0, 32'h00000800, 32'h00000000,
                   32'hFFFFFFFF, 32'h00000007, 32'h00000003, 32'h00000003};
        vName  = '{"sub", "lw", "lb", "sw", "sb", "beq", "jal", "unknown",
                   "addi_neg", "or", "slt", "and"};

        bus.Instr = 32'h0000_0000;
        bus.WE3   = 1'b0;
        bus.A3    = 5'd0;
        bus.WD3   = 32'h0000_0000;

        // Reset, then read x5 / x31
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.Instr = 32'h01F28033;
        #1;
        checkEq("rst_rd1_x5", bus.RD1, 32'h0000_0000);
        checkEq("rst_rd2_x31", bus.RD2, 32'h0000_0000);

        // Write x5 and observe same-cycle behaviour, then after the edge
        bus.WE3 = 1'b1;
        bus.A3  = 5'd5;
        bus.WD3 = 32'hDEADBEEF;
        #1;
`ifdef RF_BYPASS_EN
        checkEq("bypass_rd1", bus.RD1, 32'hDEADBEEF);
`else
        checkEq("nobypass_rd1", bus.RD1, 32'h0000_0000);
`endif
        tick();
        bus.WE3 = 1'b0;
        #1;
        checkEq("wr_x5_rd1", bus.RD1, 32'hDEADBEEF);

        // Write x31
        bus.WE3 = 1'b1;
        bus.A3  = 5'd31;
        bus.WD3 = 32'h12345678;
        tick();
        bus.WE3 = 1'b0;
        #1;
        checkEq("wr_x31_rd2", bus.RD2, 32'h12345678);
        checkEq("x5_kept", bus.RD1, 32'hDEADBEEF);

        // Write to x0 is ignored, also in the write cycle
        bus.Instr = 32'h00000033;
        bus.WE3   = 1'b1;
        bus.A3    = 5'd0;
        bus.WD3   = 32'hFFFFFFFF;
        #1;
        checkEq("x0_wcycle", bus.RD1, 32'h0000_0000);
        tick();
        bus.WE3 = 1'b0;
        #1;
        checkEq("x0_rd1", bus.RD1, 32'h0000_0000);
        checkEq("x0_rd2", bus.RD2, 32'h0000_0000);

        // Reset with simultaneous write: no bypass, reset wins
        bus.Instr = 32'h01F28033;
        rst       = 1'b1;
        bus.WE3   = 1'b1;
        bus.A3    = 5'd5;
        bus.WD3   = 32'hAAAA5555;
        #1;
        checkEq("rst_mask_rd1", bus.RD1, 32'hDEADBEEF);
        tick();
        rst     = 1'b0;
        bus.WE3 = 1'b0;
        #1;
        checkEq("rst_clr_x5", bus.RD1, 32'h0000_0000);
        checkEq("rst_clr_x31", bus.RD2, 32'h0000_0000);

        // Decoder table
        for (int i = 0; i < 12; i++) begin
            bus.Instr = vInstr[i];
            #1;
            checkEq({vName[i], "_ctrl"},
                    {19'd0, bus.RegWrite, bus.MemWrite, bus.Jump, bus.Branch, bus.ALUSrc,
                     bus.ByteAddress, bus.ResultSrc, bus.ALUControl, bus.ImmSrc},
                    {19'd0, vCtrl[i]});
            checkEq({vName[i], "_imm"}, bus.ImmExt, vImm[i]);
        end

        // Register index fields
        bus.Instr = 32'h402081B3;
        #1;
        checkEq("sub_fields", {17'd0, bus.Rs1, bus.Rs2, bus.Rd}, {17'd0, 5'd1, 5'd2, 5'd3});
        bus.Instr = 32'h007362B3;
        #1;
        checkEq("or_fields", {17'd0, bus.Rs1, bus.Rs2, bus.Rd}, {17'd0, 5'd6, 5'd7, 5'd5});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
